// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters:
// grants one requester, latches its byte/parity settings, strobes the transmitter and tracks busy_tx.
module uart_tx_arbiter #(
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 16,
    localparam int unsigned IDW         = $clog2(NREQ),
    localparam int unsigned CW          = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_parity_en,
    input  logic [NREQ-1:0]          req_parity_type,
    output logic [NREQ-1:0]          gnt,
    input  logic                     busy_tx,
    output logic [DWIDTH-1:0]        p_data_tx,
    output logic                     data_valid_tx,
    output logic                     parity_en,
    output logic                     parity_type,
    output logic [IDW-1:0]           grant_id,
    output logic                     arb_busy,
    output logic                     tx_done,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DRAIN} state_t;

    state_t              r_state,   w_state_next;
    logic [IDW-1:0]      r_rr_ptr,  w_rr_ptr_next;
    logic [NREQ-1:0]     r_gnt,     w_gnt_next;
    logic [DWIDTH-1:0]   r_data,    w_data_next;
    logic                r_pen,     w_pen_next;
    logic                r_ptype,   w_ptype_next;
    logic [IDW-1:0]      r_id,      w_id_next;
    logic [CW-1:0]       r_cnt,     w_cnt_next;
    logic                r_done,    w_done_next;
    logic                r_tout,    w_tout_next;

    logic                w_found;
    logic [IDW-1:0]      w_win;
    logic [IDW-1:0]      w_id_succ;

    // First set request searching upward from the round-robin pointer, wrapping at NREQ.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
    end

    assign w_id_succ = (32'(r_id) == NREQ - 1) ? '0 : r_id + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_rr_ptr_next = r_rr_ptr;
        w_gnt_next    = '0;
        w_data_next   = r_data;
        w_pen_next    = r_pen;
        w_ptype_next  = r_ptype;
        w_id_next     = r_id;
        w_cnt_next    = r_cnt;
        w_done_next   = 1'b0;
        w_tout_next   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // The grant pulse occupies one IDLE cycle; the following edge enters START.
                if (r_gnt != '0) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end else if (w_found) begin
                    w_gnt_next[w_win] = 1'b1;
                    w_data_next       = req_data[32'(w_win)*DWIDTH +: DWIDTH];
                    w_pen_next        = req_parity_en[w_win];
                    w_ptype_next      = req_parity_type[w_win];
                    w_id_next         = w_win;
                end
            end
            S_START: begin
                w_cnt_next = r_cnt + 1'b1;
                if (busy_tx) begin
                    w_state_next = S_DRAIN;
                end else if (r_cnt + 1'b1 == CW'(BUSY_TIMEOUT)) begin
                    w_state_next  = S_IDLE;
                    w_tout_next   = 1'b1;
                    w_rr_ptr_next = w_id_succ;
                end
            end
            S_DRAIN: begin
                if (!busy_tx) begin
                    w_state_next  = S_IDLE;
                    w_done_next   = 1'b1;
                    w_rr_ptr_next = w_id_succ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_data   <= '0;
            r_pen    <= 1'b0;
            r_ptype  <= 1'b0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_gnt    <= w_gnt_next;
            r_data   <= w_data_next;
            r_pen    <= w_pen_next;
            r_ptype  <= w_ptype_next;
            r_id     <= w_id_next;
            r_cnt    <= w_cnt_next;
            r_done   <= w_done_next;
            r_tout   <= w_tout_next;
        end
    end

    assign gnt           = r_gnt;
    assign p_data_tx     = r_data;
    assign data_valid_tx = (r_state == S_START);
    assign parity_en     = r_pen;
    assign parity_type   = r_ptype;
    assign grant_id      = r_id;
    assign arb_busy      = (r_state != S_IDLE);
    assign tx_done       = r_done;
    assign timeout_err   = r_tout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, round-robin order, parity latching,
// busy timeout, mid-frame reset and a late-withdrawn request.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_parity_en;
    logic [3:0]  req_parity_type;
    logic [3:0]  gnt;
    logic        busy_tx;
    logic [7:0]  p_data_tx;
    logic        data_valid_tx;
    logic        parity_en;
    logic        parity_type;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        tx_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .DWIDTH       (8),
        .NREQ         (4),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_parity_en   (req_parity_en),
        .req_parity_type (req_parity_type),
        .gnt             (gnt),
        .busy_tx         (busy_tx),
        .p_data_tx       (p_data_tx),
        .data_valid_tx   (data_valid_tx),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .grant_id        (grant_id),
        .arb_busy        (arb_busy),
        .tx_done         (tx_done),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then settle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic wait_gnt();
        int k = 0;
        while (gnt === 4'b0000 && k < 40) begin
            tick();
            k++;
        end
        chk("gnt_wait", 32'(gnt !== 4'b0000), 32'd1);
    endtask

    // lat = dv cycle on which busy_tx rises (0: never, expect timeout); exp_w = expected dv width.
    task automatic frame(input int id, input logic [7:0] d, input logic pe, input logic pt,
                         input int lat, input int exp_w, input int hold,
                         input logic [3:0] drop, input logic [3:0] pulse);
        int n = 0;
        wait_gnt();
        chk("gnt_bit",   32'(gnt), 32'(4'b0001 << id));
        chk("grant_id",  32'(grant_id), 32'(id));
        chk("p_data",    32'(p_data_tx), 32'(d));
        chk("parity_en", 32'(parity_en), 32'(pe));
        chk("parity_ty", 32'(parity_type), 32'(pt));
        chk("dv_at_gnt", 32'(data_valid_tx), 32'd0);
        req = req & ~drop;
        tick();
        while (data_valid_tx === 1'b1 && n < 40) begin
            n++;
            if (n == lat) busy_tx = 1'b1;
            tick();
        end
        chk("dv_width", 32'(n), 32'(exp_w));
        chk("p_data_hold", 32'(p_data_tx), 32'(d));
        if (lat == 0) begin
            chk("timeout_pulse", 32'(timeout_err), 32'd1);
            chk("arb_idle_to",   32'(arb_busy), 32'd0);
            tick();
            chk("timeout_clr",   32'(timeout_err), 32'd0);
        end else begin
            chk("no_timeout",    32'(timeout_err), 32'd0);
            chk("arb_drain",     32'(arb_busy), 32'd1);
            if (pulse != 4'b0000) begin
                req = req | pulse;
                tick();
                req = req & ~pulse;
                repeat (hold - 2) tick();
            end else begin
                repeat (hold - 1) tick();
            end
            chk("no_done_early", 32'(tx_done), 32'd0);
            busy_tx = 1'b0;
            tick();
            chk("tx_done",       32'(tx_done), 32'd1);
            chk("arb_idle",      32'(arb_busy), 32'd0);
            tick();
            chk("tx_done_clr",   32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        rst             = 1'b0;
        req             = 4'b0000;
        req_data        = '0;
        req_parity_en   = 4'b0000;
        req_parity_type = 4'b0000;
        busy_tx         = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt",   32'(gnt), 32'd0);
        chk("rst_data",  32'(p_data_tx), 32'd0);
        chk("rst_dv",    32'(data_valid_tx), 32'd0);
        chk("rst_par",   32'({parity_en, parity_type}), 32'd0);
        chk("rst_id",    32'(grant_id), 32'd0);
        chk("rst_flags", 32'({arb_busy, tx_done, timeout_err}), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_hold", 32'({gnt, arb_busy}), 32'd0);

        // Single requester
        req_data[7:0] = 8'hAA;
        req = 4'b0001;
        frame(0, 8'hAA, 1'b0, 1'b0, 3, 3, 20, 4'b0001, 4'b0000);
        repeat (3) begin
            tick();
            chk("single_no_extra", 32'({gnt, arb_busy}), 32'd0);
        end

        // Round-robin fairness from a fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req = 4'b1111;
        frame(0, 8'h10, 1'b0, 1'b0, 1, 1, 2, 4'b0000, 4'b0000);
        frame(1, 8'h21, 1'b0, 1'b0, 1, 1, 2, 4'b0000, 4'b0000);
        frame(2, 8'h32, 1'b0, 1'b0, 1, 1, 2, 4'b0000, 4'b0000);
        frame(3, 8'h43, 1'b0, 1'b0, 1, 1, 2, 4'b0000, 4'b0000);
        frame(0, 8'h10, 1'b0, 1'b0, 1, 1, 2, 4'b1111, 4'b0000);

        // Parity pass-through
        req_data[23:16] = 8'h55;
        req_data[15:8]  = 8'hAA;
        req_parity_en   = 4'b0110;
        req_parity_type = 4'b0100;
        req = 4'b0100;
        frame(2, 8'h55, 1'b1, 1'b1, 2, 2, 3, 4'b0100, 4'b0000);
        req = 4'b0010;
        frame(1, 8'hAA, 1'b1, 1'b0, 2, 2, 3, 4'b0010, 4'b0000);

        // Timeout: requester 1 wins from pointer 0, then pending requester 2 follows
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 4'b0110;
        frame(1, 8'hAA, 1'b1, 1'b0, 0, 16, 0, 4'b0010, 4'b0000);
        frame(2, 8'h55, 1'b1, 1'b1, 2, 2, 3, 4'b0100, 4'b0000);

        // Reset during DRAIN
        req = 4'b1000;
        wait_gnt();
        chk("mid_gnt3", 32'(gnt), 32'b1000);
        req = 4'b0000;
        tick();
        busy_tx = 1'b1;
        tick();
        chk("mid_in_drain", 32'({arb_busy, data_valid_tx}), 32'b10);
        req = 4'b1001;
        rst = 1'b0;
        tick();
        chk("mid_rst_gnt",   32'(gnt), 32'd0);
        chk("mid_rst_dv",    32'(data_valid_tx), 32'd0);
        chk("mid_rst_data",  32'(p_data_tx), 32'd0);
        chk("mid_rst_misc",  32'({parity_en, parity_type, grant_id, arb_busy, tx_done, timeout_err}), 32'd0);
        rst = 1'b1;
        busy_tx = 1'b0;
        tick();
        chk("mid_rr0_first", 32'(gnt), 32'b0001);
        frame(0, 8'h10, 1'b0, 1'b0, 1, 1, 2, 4'b1001, 4'b0000);

        // Late withdrawal: req[3] pulses only inside DRAIN
        req = 4'b0001;
        frame(0, 8'h10, 1'b0, 1'b0, 2, 2, 4, 4'b0001, 4'b1000);
        repeat (6) begin
            tick();
            chk("late_no_gnt", 32'({gnt, arb_busy, data_valid_tx}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
